// File: rtl/argmax_pkg.sv
// Shared types for the argmax row scheduler: FSM state, width helpers, result FIFO entry.
// Entry fields are sized for up to 2^16 rows/columns; the top uses only the low ROW_W/COL_W bits.
package argmax_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam int ROW_W_MAX = 16;
   localparam int COL_W_MAX = 16;

   function automatic int row_w(input int m);
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

   function automatic int col_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [ROW_W_MAX-1:0] row;
      logic [COL_W_MAX-1:0] idx;
      logic [31:0]          max;
      logic                 err;
   } res_entry_t;

endpackage

// File: rtl/argmax_res_fifo.sv
// Synchronous result FIFO, power-of-two depth; head visible one cycle after a push into empty.
// Push is dropped only if full with no pop (the scheduler never does this); push+pop when full is legal.
module argmax_res_fifo
   import argmax_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = res_entry_t,
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  entry_t           push_dat,
   input  logic             pop_rdy,
   output logic             pop_vld,
   output entry_t           pop_dat,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               do_push, do_pop;

   assign pop_vld = (cnt_q != '0);
   assign do_pop  = pop_vld && pop_rdy;
   assign do_push = push_vld && ((cnt_q < CNT_W'(DEPTH)) || do_pop);
   assign pop_dat = mem_q[rd_ptr_q];
   assign count   = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

endmodule

// File: rtl/argmax_row_sched.sv
// Batch scheduler feeding one row at a time to an argmax core; start 1 cycle after command, one job in flight.
// Stalls before each start while the result FIFO is full. Define ARGMAX_SCHED_WDOG_EN for the WAIT watchdog.
module argmax_row_sched
   import argmax_pkg::*;
#(
   parameter int  M           = 8,
   parameter int  N           = 8,
   parameter int  RES_DEPTH   = 4,
   parameter int  TIMEOUT_CYC = 64,
   localparam int ROW_W       = row_w(M),
   localparam int COL_W       = col_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ROW_W-1:0] cmd_row_base,
   input  logic [ROW_W:0]   cmd_row_cnt,
   output logic             core_start,
   output logic [ROW_W-1:0] core_row,
   input  logic             core_busy,
   input  logic             core_done,
   input  logic [COL_W-1:0] core_idx,
   input  logic [31:0]      core_max,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ROW_W-1:0] res_row,
   output logic [COL_W-1:0] res_idx,
   output logic [31:0]      res_max,
   output logic             res_err,
   output logic             sched_busy,
   output logic             batch_done
);

   localparam int             CNT_W = $clog2(RES_DEPTH) + 1;
   localparam logic [ROW_W:0] M_EXT = (ROW_W+1)'(M);

   state_e           state_q, state_d;
   logic [ROW_W-1:0] base_q, base_d, row_q, row_d;
   logic [ROW_W:0]   cnt_q, cnt_d, k_q, k_d;
   logic             first_q, first_d, zdone_q, zdone_d;
   logic [ROW_W:0]   row_sum;
   logic [ROW_W-1:0] row_nxt;
   logic             accept, timeout, push_vld, last;
   res_entry_t       push_dat, head_dat;
   logic [CNT_W-1:0] fifo_cnt;
   logic             unused_head;

   assign row_sum = {1'b0, base_q} + k_q;
   assign row_nxt = (row_sum >= M_EXT) ? ROW_W'(row_sum - M_EXT) : row_sum[ROW_W-1:0];

   // The first WAIT cycle may still see core_done from the previous job.
   assign accept   = (state_q == ST_WAIT) && !first_q && core_done && !core_busy;
   assign push_vld = accept || timeout;
   assign last     = ((k_q + 1'b1) == cnt_q);

`ifdef ARGMAX_SCHED_WDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   assign timeout = (state_q == ST_WAIT) && !accept && (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign wd_d    = (state_q == ST_WAIT) ? wd_q + 1'b1 : '0;

   always_ff @(posedge clk) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end

   assign res_err = head_dat.err;
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT_CYC;
   assign timeout = 1'b0;
   assign res_err = 1'b0;
`endif

   always_comb begin
      push_dat                = '0;
      push_dat.row[ROW_W-1:0] = row_q;
      if (accept) begin
         push_dat.idx[COL_W-1:0] = core_idx;
         push_dat.max            = core_max;
      end else begin
         push_dat.err = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      k_d        = k_q;
      row_d      = row_q;
      first_d    = 1'b0;
      zdone_d    = 1'b0;
      core_start = 1'b0;
      batch_done = zdone_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_row_cnt != '0) begin
                  base_d  = cmd_row_base;
                  cnt_d   = cmd_row_cnt;
                  k_d     = '0;
                  state_d = ST_ISSUE;
               end else begin
                  zdone_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (fifo_cnt < CNT_W'(RES_DEPTH)) begin
               core_start = 1'b1;
               row_d      = row_nxt;
               first_d    = 1'b1;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (push_vld) begin
               k_d = k_q + 1'b1;
               if (last) begin
                  batch_done = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         row_q   <= '0;
         first_q <= 1'b0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         row_q   <= row_d;
         first_q <= first_d;
         zdone_q <= zdone_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign sched_busy = (state_q != ST_IDLE);
   assign core_row   = row_nxt;

   argmax_res_fifo #(
      .DEPTH   (RES_DEPTH),
      .entry_t (res_entry_t)
   ) u_res_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_rdy  (res_ready),
      .pop_vld  (res_valid),
      .pop_dat  (head_dat),
      .count    (fifo_cnt)
   );

   assign res_row     = head_dat.row[ROW_W-1:0];
   assign res_idx     = head_dat.idx[COL_W-1:0];
   assign res_max     = head_dat.max;
   assign unused_head = ^head_dat;

endmodule
